// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch
// and the load/store stage. Only one transaction is outstanding at a time. The
// response goes back to whichever stage issued the request. A fetch response
// that a pipeline redirect (ifFlush) has made stale is dropped.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the fetch
// starvation guard. Fetch then wins arbitration after STARVE_LIMIT cycles of
// waiting. Without the macro, data always has priority over fetch.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    // fetch stage
    input  logic                    ifReq,
    input  logic [ADDR_WIDTH-1:0]   ifAddr,
    input  logic                    ifFlush,
    output logic                    ifGnt,
    output logic                    ifRvalid,
    output logic [DATA_WIDTH-1:0]   ifRdata,

    // memory-access stage
    input  logic                    dmReq,
    input  logic                    dmWe,
    input  logic [ADDR_WIDTH-1:0]   dmAddr,
    input  logic [DATA_WIDTH-1:0]   dmWdata,
    input  logic [DATA_WIDTH/8-1:0] dmBe,
    output logic                    dmGnt,
    output logic                    dmRvalid,
    output logic [DATA_WIDTH-1:0]   dmRdata,

    // external memory port
    output logic                    memReq,
    output logic                    memWe,
    output logic [ADDR_WIDTH-1:0]   memAddr,
    output logic [DATA_WIDTH-1:0]   memWdata,
    output logic [DATA_WIDTH/8-1:0] memBe,
    input  logic                    memReady,
    input  logic                    memRvalid,
    input  logic [DATA_WIDTH-1:0]   memRdata,

    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_DM = 2'd2
    } state_t;

    state_t state, state_next;
    logic   drop_flag;
    logic   cand_if;
    logic   cand_dm;
    logic   fetch_wins;

    // A flushed fetch request does not compete, but only in this cycle.
    assign cand_if = ifReq && !ifFlush;
    assign cand_dm = dmReq;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Count consecutive cycles in which a live fetch waits without a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!ifReq || ifFlush || ifGnt) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Data normally wins. A fetch that has starved for long enough goes first.
    assign fetch_wins = cand_if && (!cand_dm || starved);
`else
    // Strict priority: fetch wins only when there is no data request.
    assign fetch_wins = cand_if && !cand_dm;
`endif

    // Steer the memory request fields from the winning stage. Fetch is always
    // a full-word read.
    always_comb begin
        if (fetch_wins) begin
            memWe    = 1'b0;
            memAddr  = ifAddr;
            memWdata = '0;
            memBe    = '1;
        end else begin
            memWe    = dmWe;
            memAddr  = dmAddr;
            memWdata = dmWdata;
            memBe    = dmBe;
        end
    end

    // Both read-data buses pass memRdata through. Each is valid only when its
    // own rvalid is high.
    assign ifRdata = memRdata;
    assign dmRdata = memRdata;

    // State register. It also tracks whether the outstanding fetch has been
    // invalidated by a redirect.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drop_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (state == WAIT_IF && !memRvalid) begin
                drop_flag <= drop_flag || ifFlush;
            end else begin
                drop_flag <= 1'b0;
            end
        end
    end

    // Arbitration, grant, response routing and next-state logic.
    // NOTE: every output of this block gets a default first. That way no path
    // can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        memReq     = 1'b0;
        ifGnt      = 1'b0;
        dmGnt      = 1'b0;
        ifRvalid   = 1'b0;
        dmRvalid   = 1'b0;

        case (state)
            IDLE: begin
                // A stray memRvalid with no owner is ignored here.
                memReq = cand_if || cand_dm;
                if (memReq && memReady) begin
                    if (fetch_wins) begin
                        ifGnt      = 1'b1;
                        state_next = WAIT_IF;
                    end else begin
                        dmGnt      = 1'b1;
                        state_next = WAIT_DM;
                    end
                end
            end
            WAIT_IF: begin
                if (memRvalid) begin
                    // A flush earlier or in this same cycle drops the response.
                    ifRvalid   = !drop_flag && !ifFlush;
                    state_next = IDLE;
                end
            end
            WAIT_DM: begin
                if (memRvalid) begin
                    dmRvalid   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The state only clears at the next edge. Hold all handshakes low
        // while reset is asserted.
        if (rst) begin
            memReq   = 1'b0;
            ifGnt    = 1'b0;
            dmGnt    = 1'b0;
            ifRvalid = 1'b0;
            dmRvalid = 1'b0;
        end
    end

    assign busy = !rst && (state != IDLE);

    // Structural invariants.
    a_limit_valid: assert property (@(posedge clk) STARVE_LIMIT >= 1);
    a_one_grant:   assert property (@(posedge clk) disable iff (rst) !(ifGnt && dmGnt));
    a_one_rvalid:  assert property (@(posedge clk) disable iff (rst) !(ifRvalid && dmRvalid));
    a_no_req_busy: assert property (@(posedge clk) disable iff (rst) !(memReq && busy));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default parameters). The main table
// applies one record per clock cycle. Hand-written sequences then cover the
// ready stall, the starvation guard and reset in the middle of a transaction.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq, ifFlush, ifGnt, ifRvalid;
    logic [31:0] ifAddr, ifRdata;
    logic        dmReq, dmWe, dmGnt, dmRvalid;
    logic [31:0] dmAddr, dmWdata, dmRdata;
    logic [3:0]  dmBe;
    logic        memReq, memWe, memReady, memRvalid;
    logic [31:0] memAddr, memWdata, memRdata;
    logic [3:0]  memBe;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifFlush(ifFlush), .ifGnt(ifGnt),
        .ifRvalid(ifRvalid), .ifRdata(ifRdata),
        .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmWdata(dmWdata), .dmBe(dmBe),
        .dmGnt(dmGnt), .dmRvalid(dmRvalid), .dmRdata(dmRdata),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memBe(memBe), .memReady(memReady), .memRvalid(memRvalid), .memRdata(memRdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ctl packs {ifGnt, dmGnt, ifRvalid, dmRvalid, memReq, busy}
    typedef struct {
        logic        rst, if_req;
        logic [31:0] if_addr;
        logic        if_flush, dm_req, dm_we;
        logic [31:0] dm_addr, dm_wdata;
        logic [3:0]  dm_be;
        logic        mem_ready, mem_rvalid;
        logic [31:0] mem_rdata;
        logic [5:0]  ctl;
        logic        chk_mem, exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [5:0] ctl_now();
        return {ifGnt, dmGnt, ifRvalid, dmRvalid, memReq, busy};
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; ifReq = 1'b0; ifAddr = '0; ifFlush = 1'b0;
        dmReq = 1'b0; dmWe = 1'b0; dmAddr = '0; dmWdata = '0; dmBe = '0;
        memReady = 1'b0; memRvalid = 1'b0; memRdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst ifReq ifAddr ifFl dmReq dmWe dmAddr dmWdata dmBe rdy rv rdata | ctl chk we addr be wdata | chk rdata
        vecs.push_back(vec_t'{1,1,32'h100,0,1,0,32'h0,32'h0,4'h0,1,1,32'h0,        6'b000000,0,0,32'h0,4'h0,32'h0,0,32'h0});
        vecs.push_back(vec_t'{1,0,32'h0,0,0,0,32'h0,32'h0,4'h0,0,0,32'h0,          6'b000000,0,0,32'h0,4'h0,32'h0,0,32'h0});
        // fetch issue, response two cycles later
        vecs.push_back(vec_t'{0,1,32'h100,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,        6'b100010,1,0,32'h100,4'hF,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,          6'b000001,0,0,32'h0,4'h0,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,1,32'hDEAD0013,   6'b001001,0,0,32'h0,4'h0,32'h0,1,32'hDEAD0013});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,          6'b000000,0,0,32'h0,4'h0,32'h0,0,32'h0});
        // store beats fetch; fetch granted the cycle after the ack
        vecs.push_back(vec_t'{0,1,32'h104,0,1,1,32'h2000,32'h55,4'h1,1,0,32'h0,    6'b010010,1,1,32'h2000,4'h1,32'h55,0,32'h0});
        vecs.push_back(vec_t'{0,1,32'h104,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,        6'b000001,0,0,32'h0,4'h0,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,1,32'h104,0,0,0,32'h0,32'h0,4'h0,1,1,32'h0,        6'b000101,0,0,32'h0,4'h0,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,1,32'h104,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,        6'b100010,1,0,32'h104,4'hF,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,1,32'h13,         6'b001001,0,0,32'h0,4'h0,32'h0,1,32'h13});
        // flush while fetch outstanding, response 3 cycles later is dropped
        vecs.push_back(vec_t'{0,1,32'h200,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,        6'b100010,1,0,32'h200,4'hF,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,1,0,0,32'h0,32'h0,4'h0,1,0,32'h0,          6'b000001,0,0,32'h0,4'h0,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,          6'b000001,0,0,32'h0,4'h0,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,          6'b000001,0,0,32'h0,4'h0,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,1,32'hBAD,        6'b000001,0,0,32'h0,4'h0,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,          6'b000000,0,0,32'h0,4'h0,32'h0,0,32'h0});
        // next fetch delivered normally
        vecs.push_back(vec_t'{0,1,32'h300,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,        6'b100010,1,0,32'h300,4'hF,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,1,32'h77,         6'b001001,0,0,32'h0,4'h0,32'h0,1,32'h77});
        // flush coincident with the response
        vecs.push_back(vec_t'{0,1,32'h400,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,        6'b100010,1,0,32'h400,4'hF,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,1,0,0,32'h0,32'h0,4'h0,1,1,32'h99,         6'b000001,0,0,32'h0,4'h0,32'h0,0,32'h0});
        // flush in IDLE masks fetch; stray rvalid in IDLE is ignored
        vecs.push_back(vec_t'{0,1,32'h500,1,0,0,32'h0,32'h0,4'h0,1,0,32'h0,        6'b000000,0,0,32'h0,4'h0,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,1,32'h66,         6'b000000,0,0,32'h0,4'h0,32'h0,0,32'h0});
        // load; flush has no effect in WAIT_DM
        vecs.push_back(vec_t'{0,0,32'h0,0,1,0,32'h3000,32'h0,4'hF,1,0,32'h0,       6'b010010,1,0,32'h3000,4'hF,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,1,0,0,32'h0,32'h0,4'h0,1,1,32'hCAFE,       6'b000101,0,0,32'h0,4'h0,32'h0,1,32'hCAFE});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,          6'b000000,0,0,32'h0,4'h0,32'h0,0,32'h0});
        // not ready: data presented but ungranted, then it withdraws and fetch wins
        vecs.push_back(vec_t'{0,1,32'h600,0,1,1,32'h4000,32'hAB,4'h3,0,0,32'h0,    6'b000010,1,1,32'h4000,4'h3,32'hAB,0,32'h0});
        vecs.push_back(vec_t'{0,1,32'h600,0,0,0,32'h0,32'h0,4'h0,1,0,32'h0,        6'b100010,1,0,32'h600,4'hF,32'h0,0,32'h0});
        vecs.push_back(vec_t'{0,0,32'h0,0,0,0,32'h0,32'h0,4'h0,1,1,32'h12345678,   6'b001001,0,0,32'h0,4'h0,32'h0,1,32'h12345678});

        idle_inputs();
        rst = 1'b1;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; ifReq = vecs[i].if_req; ifAddr = vecs[i].if_addr;
            ifFlush = vecs[i].if_flush; dmReq = vecs[i].dm_req; dmWe = vecs[i].dm_we;
            dmAddr = vecs[i].dm_addr; dmWdata = vecs[i].dm_wdata; dmBe = vecs[i].dm_be;
            memReady = vecs[i].mem_ready; memRvalid = vecs[i].mem_rvalid;
            memRdata = vecs[i].mem_rdata;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            if (vecs[i].chk_mem) begin
                check($sformatf("vec%0d_we", i), 32'(memWe), 32'(vecs[i].exp_we));
                check($sformatf("vec%0d_addr", i), memAddr, vecs[i].exp_addr);
                check($sformatf("vec%0d_be", i), 32'(memBe), 32'(vecs[i].exp_be));
                check($sformatf("vec%0d_wdata", i), memWdata, vecs[i].exp_wdata);
            end
            if (vecs[i].chk_rd) begin
                check($sformatf("vec%0d_ifrdata", i), ifRdata, vecs[i].exp_rdata);
                check($sformatf("vec%0d_dmrdata", i), dmRdata, vecs[i].exp_rdata);
            end
            next_cycle();
        end

        // memReady low for 5 cycles: request visible, no grant, not busy
        idle_inputs();
        ifReq = 1'b1; ifAddr = 32'h700;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_ctl", i), 32'(ctl_now()), 32'(6'b000010));
            next_cycle();
        end
        memReady = 1'b1;
        @(negedge clk);
        check("stall_release_ctl", 32'(ctl_now()), 32'(6'b100010));
        check("stall_release_addr", memAddr, 32'h700);
        next_cycle();
        ifReq = 1'b0; memRvalid = 1'b1; memRdata = 32'h5;
        @(negedge clk);
        check("stall_resp_ctl", 32'(ctl_now()), 32'(6'b001001));
        next_cycle();

        // dmReq and ifReq both held, 1-cycle memory
        idle_inputs();
        dmReq = 1'b1; dmAddr = 32'h5000; dmBe = 4'hF; memReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ifReq     = !(GUARD && i > 4);
            ifAddr    = 32'h800;
            memRvalid = (i % 2 == 1);
            @(negedge clk);
            check($sformatf("starve%0d_gnt", i), 32'({ifGnt, dmGnt}),
                  32'({GUARD && i == 4, (i % 2 == 0) && !(GUARD && i == 4)}));
            next_cycle();
        end

        // reset in WAIT_DM, then a stray response after release
        idle_inputs();
        dmReq = 1'b1; dmWe = 1'b1; dmAddr = 32'h6000; dmWdata = 32'h1; dmBe = 4'hF;
        memReady = 1'b1;
        @(negedge clk);
        check("rstmid_gnt", 32'(ctl_now()), 32'(6'b010010));
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_during", 32'(ctl_now()), 32'(6'b000000));
        next_cycle();
        rst = 1'b0; memRvalid = 1'b1; memRdata = 32'hF00D;
        @(negedge clk);
        check("rstmid_stray", 32'(ctl_now()), 32'(6'b000000));
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("rstmid_after", 32'(ctl_now()), 32'(6'b000000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between the fetch stage (instruction reads) and the memory-access stage (loads/stores). Issues at most one outstanding transaction, routes the response back to its owner, and discards fetch responses invalidated by a pipeline redirect. It sits between the two pipeline stages and the memory interface, alongside the pipeline controller that drives stage control and redirect PCs.

## Interface
- `ADDR_WIDTH`, default 32: address width (PC / data address).
- `DATA_WIDTH`, default 32: data width; `DATA_WIDTH/8` byte enables.
- `STARVE_LIMIT`, default 4: stalled-fetch cycles before fetch takes priority; must be ≥1. Used only with `MEM_ARB_STARVE_GUARD_EN`.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `ifReq` in 1: fetch read request; held until `ifGnt`.
- `ifAddr` in ADDR_WIDTH: fetch address.
- `ifFlush` in 1: redirect from the controller; kills the fetch request and any in-flight fetch.
- `ifGnt` out 1: fetch request issued this cycle.
- `ifRvalid` out 1: fetch response valid.
- `ifRdata` out DATA_WIDTH: fetch response data.
- `dmReq` in 1: data request; held until `dmGnt`.
- `dmWe` in 1: 1 = store, 0 = load.
- `dmAddr` in ADDR_WIDTH: data address.
- `dmWdata` in DATA_WIDTH: store data.
- `dmBe` in DATA_WIDTH/8: byte enables.
- `dmGnt` out 1: data request issued this cycle.
- `dmRvalid` out 1: data response (load data or store ack) valid.
- `dmRdata` out DATA_WIDTH: load data.
- `memReq` out 1: request to memory.
- `memWe` out 1: write enable (0 for fetch).
- `memAddr` out ADDR_WIDTH: address.
- `memWdata` out DATA_WIDTH: write data.
- `memBe` out DATA_WIDTH/8: byte enables (all ones for fetch).
- `memReady` in 1: memory accepts the request while `memReq`=1.
- `memRvalid` in 1: memory response valid, one per accepted request, including writes.
- `memRdata` in DATA_WIDTH: response data.
- `busy` out 1: a transaction is outstanding.

## Operation
- FSM states:
  - `IDLE`: no outstanding transaction.
  - `WAIT_IF`: fetch transaction outstanding.
  - `WAIT_DM`: data transaction outstanding.
- In `IDLE`:
  - Candidate set: `dmReq`, and `ifReq && !ifFlush`.
  - `memReq` = 1 if the set is non-empty; the mem outputs are driven combinationally from the winner.
  - Default priority: data over fetch.
- Issue occurs when `memReq && memReady`.
  - The winner's `*Gnt` pulses for one cycle.
  - Next state: `WAIT_IF` or `WAIT_DM`.
  - With `memReady`=0, no grant and no state change; re-arbitration occurs the next cycle, and the winner may change.
- In `WAIT_*`:
  - `memReq` = 0.
  - On `memRvalid`, the owner's `*Rvalid` = 1 combinationally and the FSM returns to `IDLE`.
  - `ifRdata` and `dmRdata` both pass `memRdata` through; they are meaningful only with their rvalid.
- Flush tracking:
  - `ifFlush` in `WAIT_IF` sets `dropFlag`.
  - `ifFlush` coincident with `memRvalid` in `WAIT_IF` suppresses that response.
  - While `dropFlag`=1, `ifRvalid` is forced to 0.
  - `dropFlag` clears when the FSM leaves `WAIT_IF`.
- `ifFlush` has no effect in `WAIT_DM`. In `IDLE`, it masks fetch only for that cycle.
- `memRvalid` in `IDLE` is ignored (no owner).
- `busy` = (state ≠ `IDLE`).

## Timing
- Reset values:
  - state `IDLE`, `dropFlag` 0, `starveCnt` 0.
  - `memReq`, `ifGnt`, `dmGnt`, `ifRvalid`, `dmRvalid`, `busy` are all 0 while `rst`=1.
- Request-to-grant: 0 cycles (same cycle) when `IDLE`, the requester wins, and `memReady`=1.
- Response: 0-cycle pass-through from `memRvalid`.
- Next issue: earliest in the cycle after the response (1 dead cycle), so peak throughput is one transaction per 2 cycles with 1-cycle memory.
- Reset mid-transaction: FSM returns to `IDLE` and `dropFlag` clears. A later stray `memRvalid` is ignored.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - `starveCnt`, width `$clog2(STARVE_LIMIT+1)`, increments (saturating at `STARVE_LIMIT`) each cycle `ifReq && !ifFlush && !ifGnt`.
  - It clears on `ifGnt`, `ifFlush`, or `!ifReq`.
  - When `starveCnt == STARVE_LIMIT`, fetch wins arbitration in `IDLE` over a simultaneous `dmReq`.
- Undefined: strict data-over-fetch priority; no counter exists.

## Test plan
- Reset, then `ifReq`=1, `ifAddr`=0x100, `memReady`=1 → same-cycle `ifGnt`=1, `memAddr`=0x100, `memBe`=0xF, `memWe`=0. `memRvalid` with 0xDEAD0013 two cycles later → `ifRvalid`=1, `ifRdata`=0xDEAD0013, `dmRvalid`=0.
- `ifReq` and `dmReq` (store to 0x2000, data 0x55, `dmBe`=0x1) together in `IDLE` → `dmGnt`=1, `memWe`=1, `memWdata`=0x55. Fetch is granted the cycle after the store ack.
- Fetch issued, `ifFlush` pulsed in `WAIT_IF`, response arrives 3 cycles later → `ifRvalid` stays 0, FSM back in `IDLE`. A subsequent fetch response is delivered normally.
- `memReady`=0 for 5 cycles with `ifReq` held → no grant, `busy`=0. `memReady`=1 → grant.
- `dmReq` held continuously with `ifReq` held, guard enabled, `STARVE_LIMIT`=4, 1-cycle memory → fetch granted once `starveCnt` reaches 4. Guard disabled → fetch never granted while `dmReq`=1.
- `rst` asserted in `WAIT_DM`, then `memRvalid` pulsed after release → `dmRvalid`=0, `ifRvalid`=0, `busy`=0.
